// File: rtl/dma_axi_simple_csr_mst_if.sv
// Bus bundle for the CSR master: AXI4 single-beat channels plus the command/response side.
// The master modport is the DUT view; the slave modport is the view of whatever drives it.
interface dma_axi_simple_csr_mst_if #(
    parameter int AXI_WIDTH_ID = 4,
    parameter int AXI_WIDTH_AD = 32,
    parameter int AXI_WIDTH_DA = 32
);
    logic [AXI_WIDTH_ID-1:0]   AWID;
    logic [AXI_WIDTH_AD-1:0]   AWADDR;
    logic [7:0]                AWLEN;
    logic [2:0]                AWSIZE;
    logic [1:0]                AWBURST;
    logic                      AWVALID;
    logic                      AWREADY;
    logic [AXI_WIDTH_DA-1:0]   WDATA;
    logic [AXI_WIDTH_DA/8-1:0] WSTRB;
    logic                      WLAST;
    logic                      WVALID;
    logic                      WREADY;
    logic [AXI_WIDTH_ID-1:0]   BID;
    logic [1:0]                BRESP;
    logic                      BVALID;
    logic                      BREADY;
    logic [AXI_WIDTH_ID-1:0]   ARID;
    logic [AXI_WIDTH_AD-1:0]   ARADDR;
    logic [7:0]                ARLEN;
    logic [2:0]                ARSIZE;
    logic [1:0]                ARBURST;
    logic                      ARVALID;
    logic                      ARREADY;
    logic [AXI_WIDTH_ID-1:0]   RID;
    logic [AXI_WIDTH_DA-1:0]   RDATA;
    logic [1:0]                RRESP;
    logic                      RLAST;
    logic                      RVALID;
    logic                      RREADY;
    logic                      CMD_VALID;
    logic                      CMD_READY;
    logic                      CMD_WRITE;
    logic [AXI_WIDTH_AD-1:0]   CMD_ADDR;
    logic [AXI_WIDTH_DA-1:0]   CMD_WDATA;
    logic [AXI_WIDTH_DA/8-1:0] CMD_WSTRB;
    logic                      RSP_VALID;
    logic [AXI_WIDTH_DA-1:0]   RSP_RDATA;
    logic [1:0]                RSP_RESP;
    logic                      RSP_IDERR;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY,
        input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, CMD_WSTRB,
        output CMD_READY,
        output RSP_VALID, RSP_RDATA, RSP_RESP, RSP_IDERR
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY,
        output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, CMD_WSTRB,
        input  CMD_READY,
        input  RSP_VALID, RSP_RDATA, RSP_RESP, RSP_IDERR
    );
endinterface

// File: rtl/dma_axi_simple_csr_mst.sv
// One-at-a-time command to single-beat AXI4 write/read master for driving the DMA CSR port.
// Every handshake output is a flop; only the fixed burst attributes are tied off.
module dma_axi_simple_csr_mst #(
    parameter int AXI_MST_ID   = 1,
    parameter int AXI_WIDTH_ID = 4,
    parameter int AXI_WIDTH_AD = 32,
    parameter int AXI_WIDTH_DA = 32
) (
    input logic                     ARESETn,
    input logic                     ACLK,
    dma_axi_simple_csr_mst_if.master bus
);
    localparam logic [AXI_WIDTH_ID-1:0] MST_ID = AXI_WIDTH_ID'(AXI_MST_ID);

    typedef enum logic [2:0] {IDLE, WRQ, WRSP, RAQ, RRSP, DONE} state_t;

    state_t                    state;
    logic [AXI_WIDTH_AD-1:0]   addr_q;
    logic [AXI_WIDTH_DA-1:0]   wdata_q;
    logic [AXI_WIDTH_DA/8-1:0] wstrb_q;
    logic                      aw_done, w_done;
    logic                      first_beat;
    logic [AXI_WIDTH_DA-1:0]   rdata_q;
    logic [1:0]                resp_q;
    logic                      iderr_q;
    logic                      aw_hs, w_hs;

    assign aw_hs = bus.AWVALID && bus.AWREADY;
    assign w_hs  = bus.WVALID && bus.WREADY;

    assign bus.AWID    = MST_ID;
    assign bus.AWLEN   = 8'd0;
    assign bus.AWSIZE  = 3'b010;
    assign bus.AWBURST = 2'b01;
    assign bus.AWADDR  = addr_q;
    assign bus.WDATA   = wdata_q;
    assign bus.WSTRB   = wstrb_q;
    assign bus.WLAST   = 1'b1;
    assign bus.ARID    = MST_ID;
    assign bus.ARLEN   = 8'd0;
    assign bus.ARSIZE  = 3'b010;
    assign bus.ARBURST = 2'b01;
    assign bus.ARADDR  = addr_q;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state         <= IDLE;
            bus.CMD_READY <= 1'b1;
            bus.AWVALID   <= 1'b0;
            bus.WVALID    <= 1'b0;
            bus.BREADY    <= 1'b0;
            bus.ARVALID   <= 1'b0;
            bus.RREADY    <= 1'b0;
            bus.RSP_VALID <= 1'b0;
            bus.RSP_RDATA <= '0;
            bus.RSP_RESP  <= 2'b00;
            bus.RSP_IDERR <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            first_beat    <= 1'b0;
            rdata_q       <= '0;
            resp_q        <= 2'b00;
            iderr_q       <= 1'b0;
        end else begin
            bus.RSP_VALID <= 1'b0;
            case (state)
                IDLE: if (bus.CMD_VALID) begin
                    addr_q        <= {bus.CMD_ADDR[AXI_WIDTH_AD-1:2], 2'b00};
                    wdata_q       <= bus.CMD_WDATA;
                    wstrb_q       <= bus.CMD_WSTRB;
                    bus.CMD_READY <= 1'b0;
                    aw_done       <= 1'b0;
                    w_done        <= 1'b0;
                    if (bus.CMD_WRITE) begin
                        bus.AWVALID <= 1'b1;
                        bus.WVALID  <= 1'b1;
                        state       <= WRQ;
                    end else begin
                        bus.ARVALID <= 1'b1;
                        state       <= RAQ;
                    end
                end
                WRQ: begin
                    if (aw_hs) begin
                        bus.AWVALID <= 1'b0;
                        aw_done     <= 1'b1;
                    end
                    if (w_hs) begin
                        bus.WVALID <= 1'b0;
                        w_done     <= 1'b1;
                    end
                    // A handshake landing this cycle counts toward completion.
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        bus.BREADY <= 1'b1;
                        state      <= WRSP;
                    end
                end
                WRSP: if (bus.BVALID) begin
                    bus.BREADY    <= 1'b0;
                    bus.RSP_RESP  <= bus.BRESP;
                    bus.RSP_IDERR <= (bus.BID != MST_ID);
                    bus.RSP_VALID <= 1'b1;
                    state         <= DONE;
                end
                RAQ: if (bus.ARREADY) begin
                    bus.ARVALID <= 1'b0;
                    bus.RREADY  <= 1'b1;
                    first_beat  <= 1'b1;
                    state       <= RRSP;
                end
                RRSP: if (bus.RVALID) begin
                    // Data and ID come from the first beat; later beats only fold in their RRESP.
                    first_beat <= 1'b0;
                    if (first_beat) begin
                        rdata_q <= bus.RDATA;
                        resp_q  <= bus.RRESP;
                        iderr_q <= (bus.RID != MST_ID);
                    end else begin
                        resp_q <= resp_q | bus.RRESP;
                    end
                    if (bus.RLAST) begin
                        bus.RREADY    <= 1'b0;
                        bus.RSP_VALID <= 1'b1;
                        bus.RSP_RDATA <= first_beat ? bus.RDATA : rdata_q;
                        bus.RSP_RESP  <= first_beat ? bus.RRESP : (resp_q | bus.RRESP);
                        bus.RSP_IDERR <= first_beat ? (bus.RID != MST_ID) : iderr_q;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    bus.CMD_READY <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dma_axi_simple_csr_mst.sv
// Directed bench for the CSR AXI master: reactive AXI slave with per-test delays, a memory
// model that predicts every response, and literal timing/value checks against the test plan.
module tb_dma_axi_simple_csr_mst;
    localparam int MST = 1;
    localparam int IDW = 4;

    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    always #5 ACLK = ~ACLK;

    dma_axi_simple_csr_mst_if #(.AXI_WIDTH_ID(IDW), .AXI_WIDTH_AD(32), .AXI_WIDTH_DA(32)) bif ();

    dma_axi_simple_csr_mst #(.AXI_MST_ID(MST), .AXI_WIDTH_ID(IDW), .AXI_WIDTH_AD(32), .AXI_WIDTH_DA(32)) dut (
        .ARESETn(ARESETn),
        .ACLK(ACLK),
        .bus(bif)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave configuration for the current command
    int               cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0, cfg_beats = 1;
    logic [IDW-1:0]   cfg_bid = IDW'(MST), cfg_rid = IDW'(MST);
    logic [1:0]       cfg_bresp = 2'b00;
    logic [1:0][1:0]  cfg_rresp = '0;
    logic             cfg_rovr = 1'b0;
    logic [1:0][31:0] cfg_rdata = '0;

    // Reference model: what each response must be
    typedef struct {
        logic        is_read;
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        iderr;
    } rsp_t;
    rsp_t        exp_q[$];
    logic [31:0] mem_model[int];
    logic [31:0] slv_mem[int];

    // Reactive slave, updated on the falling edge
    logic        awv_q, awr_q, wv_q, wr_q, bv_q, br_q, arv_q, arr_q, rv_q, rr_q, rl_q;
    logic [31:0] awa_q, wd_q, ara_q;
    logic [3:0]  ws_q;
    logic        aw_got, w_got, ar_got;
    logic [31:0] aw_addr, w_data, ar_addr;
    logic [3:0]  w_strb;
    int          aw_wait, w_wait, b_wait, beat, last_beat_cyc;

    task automatic slave_clear();
        bif.AWREADY = 0; bif.WREADY = 0; bif.BVALID = 0; bif.BID = '0; bif.BRESP = 0;
        bif.ARREADY = 0; bif.RVALID = 0; bif.RID = '0; bif.RDATA = 0; bif.RRESP = 0; bif.RLAST = 0;
        {awv_q, awr_q, wv_q, wr_q, bv_q, br_q, arv_q, arr_q, rv_q, rr_q, rl_q} = '0;
        awa_q = 0; wd_q = 0; ara_q = 0; ws_q = 0;
        aw_got = 0; w_got = 0; ar_got = 0; aw_addr = 0; w_data = 0; ar_addr = 0; w_strb = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; beat = 0;
    endtask

    initial begin
        slave_clear();
        last_beat_cyc = -1;
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                slave_clear();
                continue;
            end
            // Held VALIDs must keep their payload
            if (awv_q && !awr_q) chk("aw_hold", {bif.AWVALID, bif.AWADDR}, {1'b1, awa_q});
            if (wv_q && !wr_q)   chk("w_hold", {bif.WVALID, bif.WSTRB, bif.WDATA}, {1'b1, ws_q, wd_q});
            if (arv_q && !arr_q) chk("ar_hold", {bif.ARVALID, bif.ARADDR}, {1'b1, ara_q});
            if (awv_q && awr_q) begin aw_got = 1; aw_addr = awa_q; end
            if (wv_q && wr_q)   begin w_got = 1; w_data = wd_q; w_strb = ws_q; end
            if (bv_q && br_q)   begin bif.BVALID = 0; aw_got = 0; w_got = 0; b_wait = 0; end
            if (arv_q && arr_q) begin ar_got = 1; ar_addr = ara_q; beat = 0; end
            if (rv_q && rr_q) begin
                if (rl_q) begin ar_got = 0; bif.RVALID = 0; bif.RLAST = 0; last_beat_cyc = cyc - 1; end
                else beat++;
            end
            if (bif.BREADY) chk("bready_after_aw_w", {aw_got, w_got}, 2'b11);
            aw_wait = bif.AWVALID ? aw_wait + 1 : 0;
            bif.AWREADY = bif.AWVALID && (aw_wait > cfg_aw_dly);
            w_wait = bif.WVALID ? w_wait + 1 : 0;
            bif.WREADY = bif.WVALID && (w_wait > cfg_w_dly);
            if (aw_got && w_got && !bif.BVALID) begin
                if (b_wait >= cfg_b_dly) begin
                    logic [31:0] old;
                    old = slv_mem.exists(int'(aw_addr >> 2)) ? slv_mem[int'(aw_addr >> 2)] : 32'h0;
                    for (int b = 0; b < 4; b++) if (w_strb[b]) old[8*b +: 8] = w_data[8*b +: 8];
                    slv_mem[int'(aw_addr >> 2)] = old;
                    bif.BVALID = 1; bif.BID = cfg_bid; bif.BRESP = cfg_bresp;
                end else b_wait++;
            end
            bif.ARREADY = bif.ARVALID;
            if (ar_got) begin
                bif.RVALID = 1;
                bif.RID    = cfg_rid;
                bif.RRESP  = cfg_rresp[beat];
                bif.RLAST  = (beat == cfg_beats - 1);
                bif.RDATA  = cfg_rovr ? cfg_rdata[beat] :
                             (slv_mem.exists(int'(ar_addr >> 2)) ? slv_mem[int'(ar_addr >> 2)] : 32'h0);
            end
            awv_q = bif.AWVALID; awr_q = bif.AWREADY; awa_q = bif.AWADDR;
            wv_q = bif.WVALID; wr_q = bif.WREADY; wd_q = bif.WDATA; ws_q = bif.WSTRB;
            bv_q = bif.BVALID; br_q = bif.BREADY;
            arv_q = bif.ARVALID; arr_q = bif.ARREADY; ara_q = bif.ARADDR;
            rv_q = bif.RVALID; rr_q = bif.RREADY; rl_q = bif.RLAST;
        end
    end

    // Response checker: every RSP_VALID against the model, RSP_RDATA held in between
    int          rsp_cnt = 0, rsp_cyc = -1;
    logic        have_rd = 0;
    logic [31:0] last_rd = 0;
    initial forever begin
        @(negedge ACLK);
        if (!ARESETn) begin exp_q.delete(); have_rd = 0; continue; end
        if (bif.RSP_VALID) begin
            rsp_cnt++;
            rsp_cyc = cyc;
            if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
            else begin
                rsp_t e;
                e = exp_q.pop_front();
                chk("rsp_resp", bif.RSP_RESP, e.resp);
                chk("rsp_iderr", bif.RSP_IDERR, e.iderr);
                if (e.is_read) chk("rsp_rdata", bif.RSP_RDATA, e.rdata);
                have_rd = e.is_read;
                last_rd = e.rdata;
            end
        end else if (have_rd) chk("rsp_rdata_hold", bif.RSP_RDATA, last_rd);
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    task automatic step();
        @(negedge ACLK);
        #1;
    endtask

    task automatic to_cycle(input int c);
        while (cyc < c) step();
    endtask

    int want = 0;

    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output int c0);
        rsp_t e;
        int   t;
        int   key;
        t = 0;
        step();
        while (!bif.CMD_READY && t < 50) begin step(); t++; end
        chk("cmd_ready_wait", bif.CMD_READY, 1);
        key = int'(a >> 2);
        e.is_read = !wr;
        e.rdata   = 0;
        if (wr) begin
            logic [31:0] old;
            old = mem_model.exists(key) ? mem_model[key] : 32'h0;
            for (int b = 0; b < 4; b++) if (s[b]) old[8*b +: 8] = d[8*b +: 8];
            mem_model[key] = old;
            e.resp  = cfg_bresp;
            e.iderr = (cfg_bid != IDW'(MST));
        end else begin
            e.rdata = cfg_rovr ? cfg_rdata[0] : (mem_model.exists(key) ? mem_model[key] : 32'h0);
            e.resp  = 2'b00;
            for (int i = 0; i < cfg_beats; i++) e.resp = e.resp | cfg_rresp[i];
            e.iderr = (cfg_rid != IDW'(MST));
        end
        exp_q.push_back(e);
        want = rsp_cnt + 1;
        bif.CMD_VALID = 1; bif.CMD_WRITE = wr; bif.CMD_ADDR = a; bif.CMD_WDATA = d; bif.CMD_WSTRB = s;
        c0 = cyc;
        step();
        bif.CMD_VALID = 0;
    endtask

    task automatic wait_rsp();
        int t;
        t = 0;
        while (rsp_cnt < want && t < 100) begin step(); t++; end
        if (rsp_cnt < want) chk("rsp_timeout", rsp_cnt, want);
    endtask

    int c0, n;

    initial begin
        bif.CMD_VALID = 0; bif.CMD_WRITE = 0; bif.CMD_ADDR = 0; bif.CMD_WDATA = 0; bif.CMD_WSTRB = 0;
        repeat (3) step();
        chk("rst_cmd_ready", bif.CMD_READY, 1);
        chk("rst_valids", {bif.AWVALID, bif.WVALID, bif.ARVALID, bif.BREADY, bif.RREADY, bif.RSP_VALID}, 6'b0);
        chk("rst_ties", {bif.AWID, bif.AWLEN, bif.AWSIZE, bif.AWBURST, bif.WLAST},
            {4'd1, 8'd0, 3'b010, 2'b01, 1'b1});
        chk("rst_rsp", {bif.RSP_RDATA, bif.RSP_RESP, bif.RSP_IDERR}, 35'd0);
        ARESETn = 1;
        step();

        // zero-wait write of 0x1000 to 0x08
        issue(1, 32'h08, 32'h0000_1000, 4'hF, c0);
        chk("wr_c1_valids", {bif.AWVALID, bif.WVALID}, 2'b11);
        chk("wr_c1_awaddr", bif.AWADDR, 32'h08);
        chk("wr_c1_wdata", {bif.WSTRB, bif.WDATA}, {4'hF, 32'h0000_1000});
        wait_rsp();
        chk("wr_rsp_cycle", rsp_cyc - c0, 3);
        chk("wr_rsp_vals", {bif.RSP_RESP, bif.RSP_IDERR}, 3'b000);
        to_cycle(c0 + 4);
        chk("cmd_ready_after_rsp", bif.CMD_READY, 1);

        // read it back
        issue(0, 32'h08, 0, 0, c0);
        chk("rd_c1_ar", {bif.ARVALID, bif.ARADDR, bif.ARLEN, bif.ARSIZE, bif.ARBURST, bif.ARID},
            {1'b1, 32'h08, 8'd0, 3'b010, 2'b01, 4'd1});
        wait_rsp();
        chk("rd_rsp_cycle", rsp_cyc - c0, 3);
        chk("rd_rdata", {bif.RSP_RDATA, bif.RSP_RESP}, {32'h0000_1000, 2'b00});

        // AW delayed 3 cycles, W immediate; partial strobes; back-to-back accept
        cfg_aw_dly = 3;
        issue(1, 32'h0C, 32'hDEAD_BEEF, 4'h3, c0);
        chk("b2b_accept", c0 - rsp_cyc, 1);
        chk("awd_c1", {bif.AWVALID, bif.WVALID}, 2'b11);
        to_cycle(c0 + 2);
        chk("awd_c2", {bif.AWVALID, bif.WVALID, bif.BREADY}, 3'b100);
        to_cycle(c0 + 4);
        chk("awd_c4", {bif.AWVALID, bif.AWADDR, bif.BREADY}, {1'b1, 32'h0C, 1'b0});
        to_cycle(c0 + 5);
        chk("awd_c5", {bif.AWVALID, bif.BREADY}, 2'b01);
        wait_rsp();
        chk("awd_rsp_cycle", rsp_cyc - c0, 6);
        n = rsp_cnt;
        repeat (3) step();
        chk("awd_single_rsp", rsp_cnt, n);
        cfg_aw_dly = 0;

        // W delayed, AW first; error BRESP and foreign BID
        cfg_w_dly = 2; cfg_bresp = 2'b11; cfg_bid = 4'd0;
        issue(1, 32'h20, 32'h1234_5678, 4'hF, c0);
        wait_rsp();
        chk("wd_rsp", {bif.RSP_RESP, bif.RSP_IDERR}, 3'b111);
        cfg_w_dly = 0; cfg_bresp = 2'b00; cfg_bid = IDW'(MST);

        // unaligned read address is forced to word alignment
        issue(0, 32'h0D, 0, 0, c0);
        chk("rd_align", bif.ARADDR, 32'h0C);
        wait_rsp();
        chk("rd_partial", bif.RSP_RDATA, 32'h0000_BEEF);

        // wrong RID with SLVERR
        cfg_rid = IDW'(MST + 1); cfg_rresp[0] = 2'b10;
        issue(0, 32'h20, 0, 0, c0);
        wait_rsp();
        chk("rd_iderr", {bif.RSP_IDERR, bif.RSP_RESP, bif.RSP_RDATA}, {1'b1, 2'b10, 32'h1234_5678});
        cfg_rid = IDW'(MST); cfg_rresp = '0;

        // two R beats, only the last carries RLAST
        cfg_beats = 2; cfg_rovr = 1; cfg_rdata[0] = 32'hA5A5_A5A5; cfg_rdata[1] = 32'h5A5A_5A5A;
        cfg_rresp[1] = 2'b01;
        issue(0, 32'h30, 0, 0, c0);
        wait_rsp();
        chk("rd2_after_last", rsp_cyc - last_beat_cyc, 1);
        chk("rd2_cycle", rsp_cyc - c0, 4);
        chk("rd2_vals", {bif.RSP_RDATA, bif.RSP_RESP}, {32'hA5A5_A5A5, 2'b01});
        cfg_beats = 1; cfg_rovr = 0; cfg_rresp = '0;

        // reset while waiting in WRSP
        cfg_b_dly = 5;
        issue(1, 32'h40, 32'h0000_CAFE, 4'hF, c0);
        n = 0;
        while (!bif.BREADY && n < 20) begin step(); n++; end
        chk("wrsp_reached", bif.BREADY, 1);
        n = rsp_cnt;
        ARESETn = 0;
        exp_q.delete();
        #1;
        chk("rst_mid_valids", {bif.AWVALID, bif.WVALID, bif.ARVALID, bif.BREADY, bif.RREADY, bif.RSP_VALID}, 6'b0);
        repeat (2) step();
        ARESETn = 1;
        cfg_b_dly = 0;
        step();
        chk("rst_mid_cmd_ready", bif.CMD_READY, 1);
        repeat (4) step();
        chk("rst_mid_no_rsp", rsp_cnt, n);

        // normal traffic after reset
        issue(1, 32'h44, 32'h0BAD_F00D, 4'hF, c0);
        wait_rsp();
        chk("post_rst_wr_cycle", rsp_cyc - c0, 3);
        issue(0, 32'h44, 0, 0, c0);
        wait_rsp();
        chk("post_rst_rd", bif.RSP_RDATA, 32'h0BAD_F00D);

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
